// File: rtl/alu_result_uart_tx_if.sv
// Result handshake between the adder stage and the UART result sink.
// The adder side uses the master modport and the sink uses the slave modport.
interface alu_result_uart_tx_if;
  logic [4:0] sum_in;
  logic       sum_valid;
  logic       sum_ready;

  modport master (
    output sum_in,
    output sum_valid,
    input  sum_ready
  );

  modport slave (
    input  sum_in,
    input  sum_valid,
    output sum_ready
  );
endinterface

// File: rtl/alu_result_uart_tx.sv
// Buffers up to four 5-bit adder results and sends each one as an 8N1 UART byte.
// A new frame starts at the end of STOP when more data is queued, so there is no idle gap.
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_result_uart_tx_if.slave        sum_if,
  output logic                       tx,
  output logic                       busy,
  output logic [2:0]                 fifo_count,
  output logic                       ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  mem_q [4];

  logic ready;
  logic push;
  logic pop;
  logic bit_end;

  // No bypass: a full FIFO refuses data even if a pop happens this cycle.
  assign ready            = (count_q != 3'd4) && !rst;
  assign sum_if.sum_ready = ready;
  assign push             = sum_if.sum_valid && ready;
  assign bit_end          = (baud_q == BAUD_LAST);

  always_comb begin
    pop = 1'b0;
    if (state_q == S_IDLE && count_q != 3'd0) begin
      pop = 1'b1;
    end
    if (state_q == S_STOP && bit_end && count_q != 3'd0) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        if (pop) begin
          state_d = S_START;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          baud_d    = 16'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (pop) begin
            state_d = S_START;
            shift_d = mem_q[rd_ptr_q];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // tx and busy are registered from the next state so they line up with it.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = shift_d[0];
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
    ovf_d = ovf_q | (sum_if.sum_valid && !ready && !rst);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      count_q   <= 3'd0;
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset; push is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {3'b000, sum_if.sum_in};
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx with CLKS_PER_BIT=4; inputs change and outputs
// are sampled on the falling edge, and the design updates on the rising edge.
module tb_alu_result_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       ovf;

  int errors;
  int checks;

  alu_result_uart_tx_if sum_if ();

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .sum_if     (sum_if.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on the falling edge right after START was entered; returns on the
  // falling edge right after the STOP bit ends.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic exp_bit;
    for (int bi = 0; bi < 10; bi++) begin
      if (bi == 0) exp_bit = 1'b0;
      else if (bi == 9) exp_bit = 1'b1;
      else exp_bit = b[bi-1];
      for (int c = 0; c < CPB; c++) begin
        check_eq({tag, "_tx"}, 32'(tx), 32'(exp_bit));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
      end
    end
    $display("frame %s byte %02h checked", tag, b);
  endtask

  task automatic send_single(input logic [4:0] v, input string tag);
    sum_if.sum_in    = v;
    sum_if.sum_valid = 1'b1;
    @(negedge clk);
    sum_if.sum_valid = 1'b0;
    check_eq({tag, "_count1"}, 32'(fifo_count), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_tx"}, 32'(tx), 32'd1);
    @(negedge clk);
    check_eq({tag, "_count0"}, 32'(fifo_count), 32'd0);
    expect_frame({3'b000, v}, tag);
    check_eq({tag, "_end_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_end_tx"}, 32'(tx), 32'd1);
    check_eq({tag, "_end_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    int low_cycles;
    errors = 0;
    checks = 0;

    // Reset held with a value offered: nothing accepted, no overflow.
    rst              = 1'b1;
    sum_if.sum_in    = 5'h1F;
    sum_if.sum_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_ready", 32'(sum_if.sum_ready), 32'd0);
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
    end
    rst              = 1'b0;
    sum_if.sum_valid = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(sum_if.sum_ready), 32'd1);
    @(negedge clk);
    check_eq("post_rst_count", 32'(fifo_count), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    $display("reset test done");

    send_single(5'h13, "single");
    send_single(5'h1E, "maxsum");

    // Burst of six: five accepted, sixth rejected, five frames back to back.
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          sum_if.sum_in    = 5'(i);
          sum_if.sum_valid = 1'b1;
          if (i == 6) begin
            #1;
            check_eq("burst_ready_full", 32'(sum_if.sum_ready), 32'd0);
            check_eq("burst_count_full", 32'(fifo_count), 32'd4);
            check_eq("burst_ovf_before", 32'(ovf), 32'd0);
          end
          @(negedge clk);
        end
        sum_if.sum_valid = 1'b0;
        check_eq("burst_ovf_set", 32'(ovf), 32'd1);
        check_eq("burst_count_after", 32'(fifo_count), 32'd4);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int f = 1; f <= 5; f++) begin
          expect_frame(8'(f), "burst");
        end
        check_eq("burst_end_busy", 32'(busy), 32'd0);
        check_eq("burst_end_count", 32'(fifo_count), 32'd0);
        check_eq("burst_ovf_sticky", 32'(ovf), 32'd1);
      end
    join

    // Push lands on the same edge STOP pops the next entry.
    fork
      begin
        sum_if.sum_in    = 5'h0A;
        sum_if.sum_valid = 1'b1;
        @(negedge clk);
        sum_if.sum_in    = 5'h15;
        @(negedge clk);
        sum_if.sum_valid = 1'b0;
        repeat (39) @(negedge clk);
        check_eq("simul_count_before", 32'(fifo_count), 32'd1);
        sum_if.sum_in    = 5'h07;
        sum_if.sum_valid = 1'b1;
        @(negedge clk);
        sum_if.sum_valid = 1'b0;
        check_eq("simul_count_after", 32'(fifo_count), 32'd1);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        expect_frame(8'h0A, "simul_a");
        expect_frame(8'h15, "simul_b");
        expect_frame(8'h07, "simul_c");
        check_eq("simul_end_busy", 32'(busy), 32'd0);
        check_eq("simul_end_count", 32'(fifo_count), 32'd0);
      end
    join

    // Reset during DATA of the first of three queued frames.
    for (int i = 0; i < 3; i++) begin
      sum_if.sum_in    = 5'(5'h11 + i);
      sum_if.sum_valid = 1'b1;
      @(negedge clk);
    end
    sum_if.sum_valid = 1'b0;
    check_eq("midrst_count_q", 32'(fifo_count), 32'd2);
    repeat (5) @(negedge clk);
    check_eq("midrst_in_frame", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_tx", 32'(tx), 32'd1);
    check_eq("midrst_count", 32'(fifo_count), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ovf_clr", 32'(ovf), 32'd0);
    rst = 1'b0;
    low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_cycles++;
    end
    check_eq("midrst_no_frame", 32'(low_cycles), 32'd0);
    check_eq("midrst_end_count", 32'(fifo_count), 32'd0);
    $display("reset mid-frame test done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
